// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe
//  Description : Control-word pipeline (ID/EX, EX/MEM, MEM/WB) with valid
//                gating, one-cycle load-use bubble, branch/jump flush and a
//                saturating stall-event counter.
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_pipe #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_regwrt,
    input  logic              id_memrd,
    input  logic              id_memwrt,
    input  logic              id_loadbyte,
    input  logic              id_readbyte,
    input  logic              id_regswp,
    input  logic [1:0]        id_alusel,
    input  logic [1:0]        id_aluop,
    input  logic [1:0]        id_regsrc,
    input  logic              id_branch,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [1:0]        ex_alusel,
    output logic [1:0]        ex_aluop,
    output logic              ex_regswp,
    output logic              mem_valid,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              mem_byte,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [1:0]        wb_regsrc,
    output logic              wb_loadbyte,
    output logic [REG_AW-1:0] wb_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ID/EX stage
    logic              ex_valid_q,    ex_valid_d;
    logic              ex_regwrt_q,   ex_regwrt_d;
    logic              ex_memrd_q,    ex_memrd_d;
    logic              ex_memwrt_q,   ex_memwrt_d;
    logic              ex_loadbyte_q, ex_loadbyte_d;
    logic              ex_readbyte_q, ex_readbyte_d;
    logic              ex_regswp_q,   ex_regswp_d;
    logic [1:0]        ex_alusel_q,   ex_alusel_d;
    logic [1:0]        ex_aluop_q,    ex_aluop_d;
    logic [1:0]        ex_regsrc_q,   ex_regsrc_d;
    logic [REG_AW-1:0] ex_rd_q,       ex_rd_d;

    // EX/MEM stage
    logic              mem_valid_q;
    logic              mem_regwrt_q;
    logic              mem_memrd_q;
    logic              mem_memwrt_q;
    logic              mem_loadbyte_q;
    logic              mem_readbyte_q;
    logic [1:0]        mem_regsrc_q;
    logic [REG_AW-1:0] mem_rd_q;

    // MEM/WB stage
    logic              wb_valid_q;
    logic              wb_regwrt_q;
    logic [1:0]        wb_regsrc_q;
    logic              wb_loadbyte_q;
    logic [REG_AW-1:0] wb_rd_q;

    logic              haz;
    logic              id_take;
    logic              id_live;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // Load-use detection; flush kills the ID instruction so it suppresses the stall
    always_comb begin
        haz     = id_valid & ex_valid_q & ex_memrd_q & ex_regwrt_q &
                  ((ex_rd_q == id_rs) | (ex_rd_q == id_rt));
        stall   = haz & ~flush;
        id_take = id_valid & ~flush & ~haz;
        // Branches advance as valid slots but never carry write/memory enables
        id_live = id_take & ~id_branch;
    end

    // ID/EX next state: bubbles capture all-zero so no X leaks into enables
    always_comb begin
        ex_valid_d    = id_take;
        ex_regwrt_d   = id_live & id_regwrt;
        ex_memrd_d    = id_live & id_memrd;
        ex_memwrt_d   = id_live & id_memwrt;
        ex_regswp_d   = id_live & id_regswp;
        ex_loadbyte_d = 1'b0;
        ex_readbyte_d = 1'b0;
        ex_alusel_d   = 2'b00;
        ex_aluop_d    = 2'b00;
        ex_regsrc_d   = 2'b00;
        ex_rd_d       = '0;
        if (id_take) begin
            ex_loadbyte_d = id_loadbyte;
            ex_readbyte_d = id_readbyte;
            ex_alusel_d   = id_alusel;
            ex_aluop_d    = id_aluop;
            ex_regsrc_d   = id_regsrc;
            ex_rd_d       = id_rd;
        end
    end

    // Saturating stall-event counter next state
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != c_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + c_CNT_ONE;
        end
    end

    // Pipeline registers: every stage reloads each cycle; reset empties all slots
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_regwrt_q    <= 1'b0;
            ex_memrd_q     <= 1'b0;
            ex_memwrt_q    <= 1'b0;
            ex_loadbyte_q  <= 1'b0;
            ex_readbyte_q  <= 1'b0;
            ex_regswp_q    <= 1'b0;
            ex_alusel_q    <= 2'b00;
            ex_aluop_q     <= 2'b00;
            ex_regsrc_q    <= 2'b00;
            ex_rd_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_regwrt_q   <= 1'b0;
            mem_memrd_q    <= 1'b0;
            mem_memwrt_q   <= 1'b0;
            mem_loadbyte_q <= 1'b0;
            mem_readbyte_q <= 1'b0;
            mem_regsrc_q   <= 2'b00;
            mem_rd_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_regwrt_q    <= 1'b0;
            wb_regsrc_q    <= 2'b00;
            wb_loadbyte_q  <= 1'b0;
            wb_rd_q        <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_regwrt_q    <= ex_regwrt_d;
            ex_memrd_q     <= ex_memrd_d;
            ex_memwrt_q    <= ex_memwrt_d;
            ex_loadbyte_q  <= ex_loadbyte_d;
            ex_readbyte_q  <= ex_readbyte_d;
            ex_regswp_q    <= ex_regswp_d;
            ex_alusel_q    <= ex_alusel_d;
            ex_aluop_q     <= ex_aluop_d;
            ex_regsrc_q    <= ex_regsrc_d;
            ex_rd_q        <= ex_rd_d;
            mem_valid_q    <= ex_valid_q;
            mem_regwrt_q   <= ex_regwrt_q;
            mem_memrd_q    <= ex_memrd_q;
            mem_memwrt_q   <= ex_memwrt_q;
            mem_loadbyte_q <= ex_loadbyte_q;
            mem_readbyte_q <= ex_readbyte_q;
            mem_regsrc_q   <= ex_regsrc_q;
            mem_rd_q       <= ex_rd_q;
            wb_valid_q     <= mem_valid_q;
            wb_regwrt_q    <= mem_regwrt_q;
            wb_regsrc_q    <= mem_regsrc_q;
            wb_loadbyte_q  <= mem_loadbyte_q;
            wb_rd_q        <= mem_rd_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Output gating: every enable is qualified by its stage valid
    always_comb begin
        ex_valid    = ex_valid_q;
        ex_alusel   = ex_valid_q ? ex_alusel_q : 2'b00;
        ex_aluop    = ex_valid_q ? ex_aluop_q  : 2'b00;
        ex_regswp   = ex_valid_q & ex_regswp_q;
        mem_valid   = mem_valid_q;
        mem_rd_en   = mem_valid_q & mem_memrd_q;
        mem_wr_en   = mem_valid_q & mem_memwrt_q;
        mem_byte    = mem_valid_q & mem_readbyte_q;
        wb_valid    = wb_valid_q;
        wb_we       = wb_valid_q & wb_regwrt_q;
        wb_regsrc   = wb_valid_q ? wb_regsrc_q : 2'b00;
        wb_loadbyte = wb_valid_q & wb_loadbyte_q;
        wb_rd       = wb_valid_q ? wb_rd_q : '0;
        stall_cnt   = stall_cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipe
//  Description : Self-checking bench for ctrl_pipe against an instruction-slot
//                reference model; second instance uses a 2-bit stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_regwrt, id_memrd, id_memwrt, id_loadbyte;
    logic       id_readbyte, id_regswp, id_branch, flush;
    logic [1:0] id_alusel, id_aluop, id_regsrc;
    logic [3:0] id_rs, id_rt, id_rd;

    logic        stall, ex_valid, ex_regswp, mem_valid, mem_rd_en, mem_wr_en, mem_byte;
    logic        wb_valid, wb_we, wb_loadbyte;
    logic [1:0]  ex_alusel, ex_aluop, wb_regsrc;
    logic [3:0]  wb_rd;
    logic [15:0] stall_cnt;

    logic        d2_stall, d2_ex_valid, d2_ex_regswp, d2_mem_valid, d2_mem_rd_en, d2_mem_wr_en;
    logic        d2_mem_byte, d2_wb_valid, d2_wb_we, d2_wb_loadbyte;
    logic [1:0]  d2_ex_alusel, d2_ex_aluop, d2_wb_regsrc;
    logic [3:0]  d2_wb_rd;
    logic [1:0]  d2_stall_cnt;

    ctrl_pipe #(.REG_AW(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_regwrt(id_regwrt),
        .id_memrd(id_memrd), .id_memwrt(id_memwrt), .id_loadbyte(id_loadbyte),
        .id_readbyte(id_readbyte), .id_regswp(id_regswp), .id_alusel(id_alusel),
        .id_aluop(id_aluop), .id_regsrc(id_regsrc), .id_branch(id_branch),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
        .ex_regswp(ex_regswp), .mem_valid(mem_valid), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_byte(mem_byte), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_regsrc(wb_regsrc), .wb_loadbyte(wb_loadbyte), .wb_rd(wb_rd),
        .stall_cnt(stall_cnt)
    );

    ctrl_pipe #(.REG_AW(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_regwrt(id_regwrt),
        .id_memrd(id_memrd), .id_memwrt(id_memwrt), .id_loadbyte(id_loadbyte),
        .id_readbyte(id_readbyte), .id_regswp(id_regswp), .id_alusel(id_alusel),
        .id_aluop(id_aluop), .id_regsrc(id_regsrc), .id_branch(id_branch),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(d2_stall), .ex_valid(d2_ex_valid), .ex_alusel(d2_ex_alusel),
        .ex_aluop(d2_ex_aluop), .ex_regswp(d2_ex_regswp), .mem_valid(d2_mem_valid),
        .mem_rd_en(d2_mem_rd_en), .mem_wr_en(d2_mem_wr_en), .mem_byte(d2_mem_byte),
        .wb_valid(d2_wb_valid), .wb_we(d2_wb_we), .wb_regsrc(d2_wb_regsrc),
        .wb_loadbyte(d2_wb_loadbyte), .wb_rd(d2_wb_rd), .stall_cnt(d2_stall_cnt)
    );

    // Reference model: each stage holds the instruction that occupies it
    typedef struct {
        logic       valid, branch, regwrt, memrd, memwrt, loadbyte, readbyte, regswp;
        logic [1:0] alusel, aluop, regsrc;
        logic [3:0] rs, rt, rd;
    } ins_t;

    ins_t        ex_s, mem_s, wb_s, idle_i;
    int unsigned scnt;
    int          vectors = 0;
    int          errors  = 0;

    function automatic ins_t mk(input logic v, br, rw, mr, mw, lb, rb, sw,
                                input logic [1:0] as, ao, sr, input logic [3:0] rs, rt, rd);
        ins_t t;
        t.valid = v;   t.branch = br;  t.regwrt = rw;   t.memrd = mr;
        t.memwrt = mw; t.loadbyte = lb; t.readbyte = rb; t.regswp = sw;
        t.alusel = as; t.aluop = ao;   t.regsrc = sr;
        t.rs = rs;     t.rt = rt;      t.rd = rd;
        return t;
    endfunction

    // Enables exist only for real, non-branch instructions
    function automatic logic en(input ins_t s, input logic f);
        return (s.valid === 1'b1 && s.branch === 1'b0) ? f : 1'b0;
    endfunction

    function automatic logic [18:0] exp_bundle();
        return {ex_s.valid, ex_s.valid ? ex_s.alusel : 2'b00, ex_s.valid ? ex_s.aluop : 2'b00,
                en(ex_s, ex_s.regswp), mem_s.valid, en(mem_s, mem_s.memrd),
                en(mem_s, mem_s.memwrt), mem_s.valid ? mem_s.readbyte : 1'b0,
                wb_s.valid, en(wb_s, wb_s.regwrt), wb_s.valid ? wb_s.regsrc : 2'b00,
                wb_s.valid ? wb_s.loadbyte : 1'b0, wb_s.valid ? wb_s.rd : 4'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check comb stall, advance model, check registers
    task automatic step(input ins_t in, input logic fl, input logic r, output logic st);
        logic h;
        ins_t nx;
        id_valid = in.valid;   id_branch = in.branch;     id_regwrt = in.regwrt;
        id_memrd = in.memrd;   id_memwrt = in.memwrt;     id_loadbyte = in.loadbyte;
        id_readbyte = in.readbyte; id_regswp = in.regswp; id_alusel = in.alusel;
        id_aluop = in.aluop;   id_regsrc = in.regsrc;     id_rs = in.rs;
        id_rt = in.rt;         id_rd = in.rd;             flush = fl;  rst = r;
        #1;
        h  = in.valid && ex_s.valid && !ex_s.branch && ex_s.memrd && ex_s.regwrt &&
             (ex_s.rd == in.rs || ex_s.rd == in.rt);
        st = h && !fl;
        chk("stall", {31'd0, stall}, {31'd0, st});
        chk("stall_w2", {31'd0, d2_stall}, {31'd0, st});
        @(posedge clk);
        if (r) begin
            ex_s = idle_i; mem_s = idle_i; wb_s = idle_i; scnt = 0;
        end else begin
            wb_s  = mem_s;
            mem_s = ex_s;
            nx    = in;
            nx.valid = in.valid && !fl && !h;
            ex_s  = nx;
            if (st && scnt < 65535) scnt++;
        end
        #1;
        chk("ex_valid",    {31'd0, ex_valid},    {31'd0, ex_s.valid});
        chk("ex_alusel",   {30'd0, ex_alusel},   {30'd0, ex_s.valid ? ex_s.alusel : 2'b00});
        chk("ex_aluop",    {30'd0, ex_aluop},    {30'd0, ex_s.valid ? ex_s.aluop : 2'b00});
        chk("ex_regswp",   {31'd0, ex_regswp},   {31'd0, en(ex_s, ex_s.regswp)});
        chk("mem_valid",   {31'd0, mem_valid},   {31'd0, mem_s.valid});
        chk("mem_rd_en",   {31'd0, mem_rd_en},   {31'd0, en(mem_s, mem_s.memrd)});
        chk("mem_wr_en",   {31'd0, mem_wr_en},   {31'd0, en(mem_s, mem_s.memwrt)});
        chk("mem_byte",    {31'd0, mem_byte},    {31'd0, mem_s.valid ? mem_s.readbyte : 1'b0});
        chk("wb_valid",    {31'd0, wb_valid},    {31'd0, wb_s.valid});
        chk("wb_we",       {31'd0, wb_we},       {31'd0, en(wb_s, wb_s.regwrt)});
        chk("wb_regsrc",   {30'd0, wb_regsrc},   {30'd0, wb_s.valid ? wb_s.regsrc : 2'b00});
        chk("wb_loadbyte", {31'd0, wb_loadbyte}, {31'd0, wb_s.valid ? wb_s.loadbyte : 1'b0});
        chk("wb_rd",       {28'd0, wb_rd},       {28'd0, wb_s.valid ? wb_s.rd : 4'd0});
        chk("stall_cnt",   {16'd0, stall_cnt},   scnt);
        chk("stall_cnt_w2", {30'd0, d2_stall_cnt}, (scnt > 3) ? 32'd3 : scnt);
        chk("dut2_bundle", {13'd0, d2_ex_valid, d2_ex_alusel, d2_ex_aluop, d2_ex_regswp,
                            d2_mem_valid, d2_mem_rd_en, d2_mem_wr_en, d2_mem_byte,
                            d2_wb_valid, d2_wb_we, d2_wb_regsrc, d2_wb_loadbyte, d2_wb_rd},
            {13'd0, exp_bundle()});
        @(negedge clk);
    endtask

    // Hold an instruction in ID until it is no longer stalled (bounded)
    task automatic issue(input ins_t in, input logic fl);
        logic st;
        int   n = 0;
        do begin
            step(in, fl, 1'b0, st);
            n++;
        end while (st && n < 4);
        chk("stall_bounded", {31'd0, st}, 32'd0);
    endtask

    task automatic idles(input int n);
        logic st;
        for (int i = 0; i < n; i++) step(idle_i, 1'b0, 1'b0, st);
    endtask

    function automatic ins_t rnd_ins();
        ins_t t;
        t = mk(($urandom % 5) != 0, ($urandom % 6) == 0, $urandom, ($urandom % 3) == 0,
               ($urandom % 4) == 0, $urandom, $urandom, $urandom,
               2'($urandom), 2'($urandom), 2'($urandom),
               4'($urandom % 4), 4'($urandom % 4), 4'($urandom % 4));
        return t;
    endfunction

    initial begin
        ins_t lw5, add5, br, sw, cur;
        logic st;
        idle_i = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0);
        ex_s = idle_i; mem_s = idle_i; wb_s = idle_i; scnt = 0;
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_branch = 1'b0;
        id_regwrt = 1'b0; id_memrd = 1'b0; id_memwrt = 1'b0; id_loadbyte = 1'b0;
        id_readbyte = 1'b0; id_regswp = 1'b0; id_alusel = 2'b00; id_aluop = 2'b00;
        id_regsrc = 2'b00; id_rs = 4'd0; id_rt = 4'd0; id_rd = 4'd0;
        @(negedge clk);

        // Reset for two cycles, then idle
        step(idle_i, 1'b0, 1'b1, st);
        step(idle_i, 1'b0, 1'b1, st);
        idles(2);

        // AND r3,r1,r2
        issue(mk(1, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'd1, 4'd2, 4'd3), 1'b0);
        idles(3);

        // LW r5 followed by a consumer of r5
        lw5  = mk(1, 0, 1, 1, 0, 1, 1, 0, 2'b01, 2'b00, 2'b01, 4'd0, 4'd0, 4'd5);
        add5 = mk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd5, 4'd6, 4'd7);
        issue(lw5, 1'b0);
        issue(add5, 1'b0);
        idles(4);

        // Branch carrying unknown write/memory-write decode bits
        br = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'd2, 4'd3, 4'd4);
        br.regwrt = 1'bx;
        br.memwrt = 1'bx;
        issue(br, 1'b0);
        idles(3);

        // Flush coincident with a load-use hazard
        issue(lw5, 1'b0);
        step(add5, 1'b1, 1'b0, st);
        idles(3);

        // SW in EX when reset arrives
        sw = mk(1, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 4'd1, 4'd2, 4'd0);
        issue(sw, 1'b0);
        step(idle_i, 1'b0, 1'b1, st);
        idles(2);

        // Repeated load-use pairs drive the narrow counter into saturation
        for (int i = 0; i < 6; i++) begin
            issue(lw5, 1'b0);
            issue(add5, 1'b0);
        end
        idles(2);

        // Randomized traffic; a stalled instruction is re-presented unchanged
        st  = 1'b0;
        cur = idle_i;
        for (int i = 0; i < 600; i++) begin
            if (!st) cur = rnd_ins();
            step(cur, ($urandom % 8) == 0, ($urandom % 80) == 0, st);
        end
        idles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
